// File: rtl/video_timing_pkg.sv
// Shared timing constants and helpers for the Spectrum-128-style raster generator.
// Default values describe the 7.095 MHz, 456 x 311 frame.
package video_timing_pkg;

  localparam int CNT_W          = 9;
  localparam int CONTEND_PHASES = 6;

  localparam int H_TOTAL_DEF      = 456;
  localparam int V_TOTAL_DEF      = 311;
  localparam int H_ACTIVE_DEF     = 256;
  localparam int V_ACTIVE_DEF     = 192;
  localparam int HBLANK_START_DEF = 320;
  localparam int HBLANK_END_DEF   = 415;
  localparam int HSYNC_START_DEF  = 336;
  localparam int HSYNC_LEN_DEF    = 32;
  localparam int VBLANK_START_DEF = 248;
  localparam int VBLANK_LEN_DEF   = 8;
  localparam int VSYNC_START_DEF  = 248;
  localparam int VSYNC_LEN_DEF    = 4;
  localparam int INT_LINE_DEF     = 248;
  localparam int INT_HPOS_DEF     = 0;
  localparam int INT_LEN_DEF      = 72;

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic logic in_window(input cnt_t pos, input int first, input int len);
    int p;
    p = int'(pos);
    return (p >= first) && (p < first + len);
  endfunction

endpackage

// File: rtl/video_timing_cpu_clock_gate.sv
// CPU clock-enable with ULA-style memory contention. Fed with the upcoming raster
// position so the registered pulse lines up with the hcount shown on the same cycle.
module video_timing_cpu_clock_gate
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic             clock70,
  input  logic             reset,
  input  logic [CNT_W-1:0] hcount,
  input  logic [CNT_W-1:0] vcount,
  input  logic             contend_req,
  output logic             cpu_ce
);

  logic cpu_ce_reg;
  logic stall;

  // The shifter owns the bus for the first six T-state phases of every 8-T group.
  always_comb begin
    stall = contend_req
         && (vcount < cnt_t'(V_ACTIVE))
         && (hcount < cnt_t'(H_ACTIVE))
         && (hcount[3:1] < 3'(CONTEND_PHASES));
  end

  always_ff @(posedge clock70) begin
    if (reset) begin
      cpu_ce_reg <= 1'b0;
    end else begin
      cpu_ce_reg <= hcount[0] && !stall;
    end
  end

  assign cpu_ce = cpu_ce_reg;

endmodule

// File: rtl/video_timing.sv
// Raster counters, sync/blank/border flags, frame interrupt and flash phase.
// Flags are decoded from the next counter state so they align with hcount/vcount.
module video_timing
  import video_timing_pkg::*;
#(
  parameter int H_TOTAL      = H_TOTAL_DEF,
  parameter int V_TOTAL      = V_TOTAL_DEF,
  parameter int H_ACTIVE     = H_ACTIVE_DEF,
  parameter int V_ACTIVE     = V_ACTIVE_DEF,
  parameter int HBLANK_START = HBLANK_START_DEF,
  parameter int HBLANK_END   = HBLANK_END_DEF,
  parameter int HSYNC_START  = HSYNC_START_DEF,
  parameter int HSYNC_LEN    = HSYNC_LEN_DEF,
  parameter int VBLANK_START = VBLANK_START_DEF,
  parameter int VBLANK_LEN   = VBLANK_LEN_DEF,
  parameter int VSYNC_START  = VSYNC_START_DEF,
  parameter int VSYNC_LEN    = VSYNC_LEN_DEF,
  parameter int INT_LINE     = INT_LINE_DEF,
  parameter int INT_HPOS     = INT_HPOS_DEF,
  parameter int INT_LEN      = INT_LEN_DEF
) (
  input  logic             clock70,
  input  logic             reset,
  input  logic             contend_req,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             blank,
  output logic             border,
  output logic             int_n,
  output logic             cpu_ce,
  output logic             flash
);

  cnt_t        hcount_reg, vcount_reg;
  cnt_t        hcount_next, vcount_next;
  logic        h_wrap, v_wrap;
  logic [4:0]  frame_reg;
  logic        hsync_reg, vsync_reg, blank_reg, border_reg, int_n_reg;
  logic        blank_next, int_start;
  logic [15:0] int_cnt_reg;

  always_comb begin
    h_wrap      = (hcount_reg == cnt_t'(H_TOTAL - 1));
    v_wrap      = h_wrap && (vcount_reg == cnt_t'(V_TOTAL - 1));
    hcount_next = h_wrap ? '0 : hcount_reg + 1'b1;
    vcount_next = v_wrap ? '0 : (h_wrap ? vcount_reg + 1'b1 : vcount_reg);
    blank_next  = in_window(hcount_next, HBLANK_START, HBLANK_END - HBLANK_START + 1)
               || in_window(vcount_next, VBLANK_START, VBLANK_LEN);
    int_start   = (vcount_next == cnt_t'(INT_LINE)) && (hcount_next == cnt_t'(INT_HPOS));
  end

  always_ff @(posedge clock70) begin
    if (reset) begin
      hcount_reg  <= '0;
      vcount_reg  <= '0;
      frame_reg   <= '0;
      hsync_reg   <= 1'b0;
      vsync_reg   <= 1'b0;
      blank_reg   <= 1'b0;
      border_reg  <= 1'b0;
      int_n_reg   <= 1'b1;
      int_cnt_reg <= '0;
    end else begin
      hcount_reg <= hcount_next;
      vcount_reg <= vcount_next;
      if (v_wrap) begin
        frame_reg <= frame_reg + 1'b1;
      end
      hsync_reg  <= in_window(hcount_next, HSYNC_START, HSYNC_LEN);
      vsync_reg  <= in_window(vcount_next, VSYNC_START, VSYNC_LEN);
      blank_reg  <= blank_next;
      border_reg <= !blank_next
                 && ((hcount_next >= cnt_t'(H_ACTIVE)) || (vcount_next >= cnt_t'(V_ACTIVE)));
      // A free-running down-counter lets the pulse run across a line wrap.
      if (int_start) begin
        int_n_reg   <= 1'b0;
        int_cnt_reg <= 16'(INT_LEN - 1);
      end else if (int_cnt_reg != '0) begin
        int_n_reg   <= 1'b0;
        int_cnt_reg <= int_cnt_reg - 1'b1;
      end else begin
        int_n_reg   <= 1'b1;
      end
    end
  end

  video_timing_cpu_clock_gate #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_cpu_clock_gate (
    .clock70     (clock70),
    .reset       (reset),
    .hcount      (hcount_next),
    .vcount      (vcount_next),
    .contend_req (contend_req),
    .cpu_ce      (cpu_ce)
  );

  assign hcount = hcount_reg;
  assign vcount = vcount_reg;
  assign hsync  = hsync_reg;
  assign vsync  = vsync_reg;
  assign blank  = blank_reg;
  assign border = border_reg;
  assign int_n  = int_n_reg;
  assign flash  = frame_reg[4];

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: a default-timing instance for line-level behaviour and a
// shrunken-frame instance so whole frames, the interrupt and flash fit in the run.
module tb_video_timing;

  typedef struct {
    int ht, vt, ha, va, hbs, hbe, hss, hsl, vbs, vbl, vss, vsl, il, ih, ilen;
  } cfg_t;

  typedef struct {
    int h, v;
    bit hs, vs, bl, bo, intn, ce, fl;
  } exp_t;

  logic       clock70 = 1'b0;
  logic       reset;
  logic       contend_req;
  logic [8:0] d_hcount, d_vcount, s_hcount, s_vcount;
  logic       d_hsync, d_vsync, d_blank, d_border, d_int_n, d_cpu_ce, d_flash;
  logic       s_hsync, s_vsync, s_blank, s_border, s_int_n, s_cpu_ce, s_flash;

  int   t;
  int   total = 0;
  int   passed = 0;
  cfg_t cd, cs;

  always #5 clock70 = ~clock70;

  video_timing dut_d (
    .clock70(clock70), .reset(reset), .contend_req(contend_req),
    .hcount(d_hcount), .vcount(d_vcount), .hsync(d_hsync), .vsync(d_vsync),
    .blank(d_blank), .border(d_border), .int_n(d_int_n), .cpu_ce(d_cpu_ce),
    .flash(d_flash)
  );

  video_timing #(
    .H_TOTAL(40), .V_TOTAL(20), .H_ACTIVE(24), .V_ACTIVE(12),
    .HBLANK_START(28), .HBLANK_END(35), .HSYNC_START(30), .HSYNC_LEN(3),
    .VBLANK_START(15), .VBLANK_LEN(3), .VSYNC_START(15), .VSYNC_LEN(2),
    .INT_LINE(14), .INT_HPOS(30), .INT_LEN(15)
  ) dut_s (
    .clock70(clock70), .reset(reset), .contend_req(contend_req),
    .hcount(s_hcount), .vcount(s_vcount), .hsync(s_hsync), .vsync(s_vsync),
    .blank(s_blank), .border(s_border), .int_n(s_int_n), .cpu_ce(s_cpu_ce),
    .flash(s_flash)
  );

  // Outputs as a pure function of clocks elapsed since reset release.
  function automatic exp_t model(input cfg_t c, input int tt, input bit cont);
    exp_t e;
    int fl_len, frame, pos, d;
    fl_len = c.ht * c.vt;
    frame  = tt / fl_len;
    pos    = tt % fl_len;
    e.h    = pos % c.ht;
    e.v    = pos / c.ht;
    e.hs   = (e.h >= c.hss) && (e.h < c.hss + c.hsl);
    e.vs   = (e.v >= c.vss) && (e.v < c.vss + c.vsl);
    e.bl   = ((e.h >= c.hbs) && (e.h <= c.hbe)) || ((e.v >= c.vbs) && (e.v < c.vbs + c.vbl));
    e.bo   = !e.bl && ((e.h >= c.ha) || (e.v >= c.va));
    d      = pos - (c.il * c.ht + c.ih);
    if (d < 0 && frame > 0) d += fl_len;
    e.intn = !((d >= 0) && (d < c.ilen));
    e.ce   = (e.h % 2 == 1) && !(cont && (e.v < c.va) && (e.h < c.ha) && (((e.h / 2) % 8) < 6));
    e.fl   = ((frame % 32) >= 16);
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, req);
  endtask

  task automatic lit(input string name, input int act, input int req);
    chk(name, act, req);
    $display("literal %s t=%0d value=%0d", name, t, act);
  endtask

  task automatic compare_all(input bit cont);
    exp_t e;
    e = model(cd, t, cont);
    chk("default_outputs",
        int'({d_hcount, d_vcount, d_hsync, d_vsync, d_blank, d_border, d_int_n, d_cpu_ce, d_flash}),
        int'({9'(e.h), 9'(e.v), e.hs, e.vs, e.bl, e.bo, e.intn, e.ce, e.fl}));
    e = model(cs, t, cont);
    chk("small_outputs",
        int'({s_hcount, s_vcount, s_hsync, s_vsync, s_blank, s_border, s_int_n, s_cpu_ce, s_flash}),
        int'({9'(e.h), 9'(e.v), e.hs, e.vs, e.bl, e.bo, e.intn, e.ce, e.fl}));
  endtask

  task automatic literals();
    int l10;
    l10 = 10 * 456;
    if (t == 11)  lit("ce_h11_stalled", d_cpu_ce, 0);
    if (t == 13)  lit("ce_h13_first", d_cpu_ce, 1);
    if (t == 17)  lit("ce_h17_stalled", d_cpu_ce, 0);
    if (t == 29)  lit("ce_h29_free", d_cpu_ce, 1);
    if (t == 455) lit("h_last", d_hcount, 455);
    if (t == 456) begin
      lit("h_wrap", d_hcount, 0);
      lit("v_inc", d_vcount, 1);
    end
    if (t == l10 + 335) lit("hsync_before", d_hsync, 0);
    if (t == l10 + 336) lit("hsync_first", d_hsync, 1);
    if (t == l10 + 367) lit("hsync_last", d_hsync, 1);
    if (t == l10 + 368) lit("hsync_after", d_hsync, 0);
    if (t == l10 + 319) lit("blank_before", d_blank, 0);
    if (t == l10 + 320) lit("blank_first", d_blank, 1);
    if (t == l10 + 415) lit("blank_last", d_blank, 1);
    if (t == l10 + 416) lit("border_after_blank", d_border, 1);
    if (t == l10 + 255) lit("border_before", d_border, 0);
    if (t == l10 + 256) lit("border_first", d_border, 1);
    if (t == 589) lit("int_before", s_int_n, 1);
    if (t == 590) lit("int_start", s_int_n, 0);
    if (t == 604) lit("int_last_wrapped", s_int_n, 0);
    if (t == 605) lit("int_end", s_int_n, 1);
    if (t == 800) lit("frame_wrap_v", s_vcount, 0);
    if (t == 5401) lit("ce_nonactive_line", s_cpu_ce, 1);
    if (t == 16 * 800 - 1) lit("flash_pre16", s_flash, 0);
    if (t == 16 * 800)     lit("flash_rise", s_flash, 1);
    if (t == 32 * 800 - 1) lit("flash_pre32", s_flash, 1);
    if (t == 32 * 800)     lit("flash_fall", s_flash, 0);
  endtask

  task automatic step(input bit rst, input bit cont);
    reset       = rst;
    contend_req = cont;
    @(posedge clock70);
    if (rst) t = 0;
    else t++;
    @(negedge clock70);
    compare_all(cont);
    literals();
  endtask

  initial begin
    int tn;
    bit c;
    cd = '{456, 311, 256, 192, 320, 415, 336, 32, 248, 8, 248, 4, 248, 0, 72};
    cs = '{40, 20, 24, 12, 28, 35, 30, 3, 15, 3, 15, 2, 14, 30, 15};
    t = 0;
    reset = 1'b1;
    contend_req = 1'b0;

    repeat (3) step(1'b1, 1'b0);
    for (int i = 0; i < 6200; i++) begin
      tn = t + 1;
      if (tn <= 456) c = 1'b1;
      else if (tn < 2000) c = 1'($urandom_range(1, 0));
      else c = (tn >= 5400);
      step(1'b0, c);
    end

    step(1'b1, 1'b1);
    lit("rst_h", d_hcount, 0);
    lit("rst_v", d_vcount, 0);
    lit("rst_int_n", s_int_n, 1);
    lit("rst_cpu_ce", d_cpu_ce, 0);
    lit("rst_flash", s_flash, 0);

    for (int i = 0; i < 33 * 800 + 20; i++) step(1'b0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
